// File: rtl/mem_wb_pkg.sv
// Shared pipeline-register constants, the write-back bundle type, and the
// stall/flush decode used by every pipeline register.
package mem_wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned STALL_W    = 6;

    localparam int unsigned STALL_MEM  = 4;
    localparam int unsigned STALL_WB   = 5;

    localparam logic [REG_ADDR_W-1:0] NOP_REG   = '0;
    localparam logic [WORD_W-1:0]     ZERO_WORD = '0;

    // Everything the writeback stage consumes, grouped so that capture,
    // hold and bubble are each one assignment.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [WORD_W-1:0]     wdata;
        logic                  whilo;
        logic [WORD_W-1:0]     hi;
        logic [WORD_W-1:0]     lo;
    } wb_bundle_t;

    localparam wb_bundle_t WB_BUBBLE = '{
        wd:    NOP_REG,
        wreg:  1'b0,
        wdata: ZERO_WORD,
        whilo: 1'b0,
        hi:    ZERO_WORD,
        lo:    ZERO_WORD
    };

    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2
    } stage_act_e;

    // Flush beats any stall. Upstream stalled while downstream runs means a
    // bubble; both stalled means hold. The illegal "WB stalled, MEM running"
    // combination falls through to capture.
    function automatic stage_act_e stage_action(input logic flush,
                                                input logic stall_up,
                                                input logic stall_dn);
        if (flush)
            return ACT_BUBBLE;
        if (stall_up && !stall_dn)
            return ACT_BUBBLE;
        if (stall_up)
            return ACT_HOLD;
        return ACT_CAPTURE;
    endfunction

endpackage

// File: rtl/mem_wb.sv
// MEM -> WB pipeline register with stall/flush handling and a retired
// write-back counter for debug/performance readout.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic [4:0]       mem_wd,
    input  logic             mem_wreg,
    input  logic [31:0]      mem_wdata,
    input  logic             mem_whilo,
    input  logic [31:0]      mem_hi,
    input  logic [31:0]      mem_lo,
    output logic [4:0]       wb_wd,
    output logic             wb_wreg,
    output logic [31:0]      wb_wdata,
    output logic             wb_whilo,
    output logic [31:0]      wb_hi,
    output logic [31:0]      wb_lo,
    output logic [CNT_W-1:0] retire_cnt
);

    wb_bundle_t       wb_d, wb_q;
    wb_bundle_t       mem_bundle;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    stage_act_e       act;
    logic             unused_stall_lo;

    // Only the MEM and WB stall bits matter to this stage.
    assign unused_stall_lo = ^stall[STALL_MEM-1:0];

    // Gather the MEM-stage request and decode what this edge should do.
    always_comb begin
        mem_bundle = '{
            wd:    mem_wd,
            wreg:  mem_wreg,
            wdata: mem_wdata,
            whilo: mem_whilo,
            hi:    mem_hi,
            lo:    mem_lo
        };
        act = stage_action(flush, stall[STALL_MEM], stall[STALL_WB]);
    end

    // Next bundle, and count the presented write-back if WB consumes it.
    always_comb begin
        wb_d  = wb_q;
        cnt_d = cnt_q;
        unique case (act)
            ACT_CAPTURE: wb_d = mem_bundle;
            ACT_BUBBLE:  wb_d = WB_BUBBLE;
            ACT_HOLD:    wb_d = wb_q;
            default:     wb_d = wb_q;
        endcase
        if ((wb_q.wreg || wb_q.whilo) && !stall[STALL_WB])
            cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q  <= WB_BUBBLE;
            cnt_q <= '0;
        end else begin
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign wb_wd      = wb_q.wd;
    assign wb_wreg    = wb_q.wreg;
    assign wb_wdata   = wb_q.wdata;
    assign wb_whilo   = wb_q.whilo;
    assign wb_hi      = wb_q.hi;
    assign wb_lo      = wb_q.lo;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
// A second instance with a 4-bit counter exercises wrap-around.
module tb_mem_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;

    logic [4:0]  wb_wd,    s_wd;
    logic        wb_wreg,  s_wreg;
    logic [31:0] wb_wdata, s_wdata;
    logic        wb_whilo, s_whilo;
    logic [31:0] wb_hi,    s_hi;
    logic [31:0] wb_lo,    s_lo;
    logic [31:0] retire_cnt;
    logic [3:0]  s_retire_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mem_wb #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .retire_cnt(retire_cnt)
    );

    mem_wb #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .wb_wd(s_wd), .wb_wreg(s_wreg), .wb_wdata(s_wdata),
        .wb_whilo(s_whilo), .wb_hi(s_hi), .wb_lo(s_lo),
        .retire_cnt(s_retire_cnt)
    );

    // ---------------- behavioural model ----------------
    // What WB currently presents, and how many write-backs it has consumed.
    logic [4:0]  m_wd    = '0;
    logic        m_wreg  = 1'b0;
    logic [31:0] m_wdata = '0;
    logic        m_whilo = 1'b0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;
    longint unsigned m_retired = 0;

    always @(posedge clk) begin
        if (rst) begin
            {m_wd, m_wreg, m_wdata, m_whilo, m_hi, m_lo} = '0;
            m_retired = 0;
        end else begin
            // WB consumes what it was showing unless WB itself is stalled.
            if ((m_wreg || m_whilo) && !stall[5])
                m_retired = m_retired + 1;
            if (flush || (stall[4] && !stall[5])) begin
                {m_wd, m_wreg, m_wdata, m_whilo, m_hi, m_lo} = '0;
            end else if (!stall[4]) begin
                m_wd = mem_wd; m_wreg = mem_wreg; m_wdata = mem_wdata;
                m_whilo = mem_whilo; m_hi = mem_hi; m_lo = mem_lo;
            end
            // both stalled: WB keeps showing the same request
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_wd",     64'(wb_wd),     64'(m_wd));
            chk("m_wreg",   64'(wb_wreg),   64'(m_wreg));
            chk("m_wdata",  64'(wb_wdata),  64'(m_wdata));
            chk("m_whilo",  64'(wb_whilo),  64'(m_whilo));
            chk("m_hi",     64'(wb_hi),     64'(m_hi));
            chk("m_lo",     64'(wb_lo),     64'(m_lo));
            chk("m_cnt",    64'(retire_cnt), m_retired & 64'hFFFF_FFFF);
            chk("m_s_wd",   64'({s_wd, s_wreg, s_whilo}), 64'({m_wd, m_wreg, m_whilo}));
            chk("m_s_data", {s_wdata, s_hi ^ s_lo}, {m_wdata, m_hi ^ m_lo});
            chk("m_s_cnt",  64'(s_retire_cnt), m_retired & 64'hF);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_mem(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                           input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        mem_whilo = whilo; mem_hi = hi; mem_lo = lo;
    endtask

    initial begin
        // Reset with every input nonzero.
        rst = 1'b1; stall = 6'b111111; flush = 1'b1;
        set_mem(5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
        @(negedge clk);
        cyc(2);
        chk("rst_wd",    64'(wb_wd), 64'd0);
        chk("rst_en",    64'({wb_wreg, wb_whilo}), 64'd0);
        chk("rst_data",  {wb_wdata, wb_hi | wb_lo}, 64'd0);
        chk("rst_cnt",   64'(retire_cnt), 64'd0);
        chk("rst_scnt",  64'(s_retire_cnt), 64'd0);
        cmp_en = 1'b1;

        // Pass-through.
        rst = 1'b0; stall = '0; flush = 1'b0;
        set_mem(5'd3, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0);
        cyc(1);
        chk("pt_wd",    64'(wb_wd), 64'd3);
        chk("pt_wreg",  64'(wb_wreg), 64'd1);
        chk("pt_wdata", 64'(wb_wdata), 64'hDEAD_BEEF);
        chk("pt_cnt0",  64'(retire_cnt), 64'd0);

        // Bubble: MEM stalled, WB runs.
        stall = 6'b010000;
        cyc(1);
        chk("bub_wreg", 64'(wb_wreg), 64'd0);
        chk("bub_wd",   64'(wb_wd), 64'd0);
        chk("bub_cnt",  64'(retire_cnt), 64'd1);

        // Hold across three cycles while inputs change.
        stall = '0;
        set_mem(5'd7, 1'b1, 32'h1234_5678, 1'b0, 32'd0, 32'd0);
        cyc(1);
        stall = 6'b110000;
        for (int i = 0; i < 3; i++) begin
            set_mem(5'(i + 10), 1'b1, 32'($urandom), 1'b1, 32'($urandom), 32'($urandom));
            cyc(1);
            chk("hold_wd",    64'(wb_wd), 64'd7);
            chk("hold_wdata", 64'(wb_wdata), 64'h1234_5678);
            chk("hold_cnt",   64'(retire_cnt), 64'd1);
        end

        // Flush beats a full stall.
        flush = 1'b1;
        set_mem(5'd9, 1'b1, 32'h0BAD_F00D, 1'b1, 32'd1, 32'd2);
        cyc(1);
        chk("fl_wd",   64'(wb_wd), 64'd0);
        chk("fl_en",   64'({wb_wreg, wb_whilo}), 64'd0);
        chk("fl_data", {wb_wdata, wb_hi | wb_lo}, 64'd0);
        chk("fl_cnt",  64'(retire_cnt), 64'd1);

        // Counter wrap: 17 retired writes on a 4-bit counter reads 1.
        rst = 1'b1; flush = 1'b0; stall = '0;
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_mem(5'(i), 1'b1, 32'(i * 3), 1'b0, 32'd0, 32'd0);
            cyc(1);
        end
        set_mem(5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        cyc(1);
        chk("wrap_small", 64'(s_retire_cnt), 64'd1);
        chk("wrap_big",   64'(retire_cnt), 64'd17);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            rst   = (r < 2);
            flush = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 9))
                0, 1:    stall = {2'b01, 4'($urandom)};
                2, 3, 4: stall = {2'b11, 4'($urandom)};
                5:       stall = {2'b10, 4'($urandom)};
                default: stall = {2'b00, 4'($urandom)};
            endcase
            set_mem(5'($urandom), 1'($urandom), 32'($urandom),
                    1'($urandom), 32'($urandom), 32'($urandom));
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb.md
# mem_wb

Pipeline register between the memory-access stage and register-file writeback. It captures the memory stage's write-back request each cycle: destination register, write enable, data, and HI/LO update. It honours the pipeline stall vector and flush, inserting bubbles or holding as required. It also keeps a retired-write counter for debug and performance readout.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-write counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  6  pipeline stall vector; bit 4 = MEM stalled, bit 5 = WB stalled.
- `flush`  in  1  exception flush; kills the in-flight write-back.
- `mem_wd`  in  5  destination register address from MEM.
- `mem_wreg`  in  1  GPR write enable from MEM.
- `mem_wdata`  in  32  GPR write data from MEM.
- `mem_whilo`  in  1  HI/LO write enable from MEM.
- `mem_hi`  in  32  HI value from MEM.
- `mem_lo`  in  32  LO value from MEM.
- `wb_wd`  out  5  registered destination address to regfile.
- `wb_wreg`  out  1  registered GPR write enable.
- `wb_wdata`  out  32  registered GPR write data.
- `wb_whilo`  out  1  registered HI/LO write enable.
- `wb_hi`  out  32  registered HI.
- `wb_lo`  out  32  registered LO.
- `retire_cnt`  out  CNT_W  count of cycles in which a valid write-back (`wb_wreg` or `wb_whilo`) was presented.

## Operation
Priority per rising edge, highest first:
- `rst`=1: all `wb_*` outputs go to zero (`wb_wd`=0, enables 0, data 0). `retire_cnt` goes to 0.
- `flush`=1: insert a bubble. All `wb_*` outputs go to zero; counter is not cleared.
- `stall[4]`=1 and `stall[5]`=0: MEM is held but WB proceeds. Insert a bubble, same values as flush.
- `stall[4]`=1 and `stall[5]`=1: hold all `wb_*` outputs unchanged.
- `stall[4]`=0: capture all `mem_*` inputs into the corresponding `wb_*`.
- `stall[4]`=0 with `stall[5]`=1 is illegal (the stall vector is monotone). The block treats it as a capture.

Further rules:
- Write to register 0: forwarded as-is. Suppressing writes to r0 is the regfile's job.
- `retire_cnt` increments by 1 on each edge where the current (pre-edge) `wb_wreg | wb_whilo` = 1 and `stall[5]`=0. The increment is suppressed when `rst`=1.
- A bubble itself never counts.
- `retire_cnt` wraps modulo 2^CNT_W with no saturation.

## Timing
- Latency: exactly 1 cycle from `mem_*` to `wb_*` when not stalled.
- Outputs are purely registered, with no combinational path from inputs to outputs.
- Reset asserted mid-stall clears the register on that edge. The first capture is possible on the first edge with `rst`=0.
- Flush and stall in the same cycle: flush wins and a bubble is inserted.
- The held value persists for as many cycles as `stall[5:4]`=2'b11.

## Structure
- Shared package: register-address width (5), word width (32), NOP register address (0), zero word, and stall-vector bit indices (MEM=4, WB=5). These constants are reused by all pipeline registers.
- Single module. Datapath fields are grouped as one packed write-back bundle so that capture, hold and bubble are each a single assignment.
- No sub-module is needed.

## Test plan
- Reset: drive all inputs nonzero with `rst`=1 for 2 cycles. After the edge, every `wb_*` = 0 and `retire_cnt` = 0.
- Pass-through: drive `mem_wd`=5'd3, `mem_wreg`=1, `mem_wdata`=32'hDEADBEEF with stall=0. The next cycle shows `wb_*` equal to these values. One cycle later `retire_cnt`=1.
- Bubble: `wb` holds r3/DEADBEEF and `stall`=6'b010000. The next edge gives `wb_wreg`=0 and `wb_wd`=0. `retire_cnt` still increments once, for the r3 write.
- Hold: `wb` holds r7/0x12345678 and `stall`=6'b110000 for 3 cycles while inputs change. `wb_*` stays r7/0x12345678 and `retire_cnt` is unchanged across those cycles.
- Flush priority: `flush`=1, `stall`=6'b110000, and MEM carries HI/LO write hi=1, lo=2. The next edge gives all `wb_*` = 0.
- Counter wrap: with CNT_W=4, issue 17 consecutive valid writes. `retire_cnt` reads 1.
